// File: rtl/cmp_sel_shift_pipe.sv
// Three-stage add/compare/select/shift pipeline with valid/ready on both sides.
// Optional output-handshake counter enabled by defining CMP_SEL_SHIFT_STATS_EN.
module cmp_sel_shift_pipe #(
    parameter int WIDTH     = 64,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] x,
    output logic [OUT_WIDTH-1:0] z
`ifdef CMP_SEL_SHIFT_STATS_EN
    ,
    output logic [15:0]          xfer_count
`endif
);

    logic             s1_valid, s2_valid, s3_valid;
    logic             s1_load, s2_load, s3_load;
    logic [WIDTH-1:0] s1_d, s1_e, s1_f;
    logic             s1_lt, s1_eq;
    logic [WIDTH-1:0] s2_g, s2_h;
    logic             s2_lt, s2_eq;

    logic [WIDTH-1:0] d_next, e_next, f_next;
    logic             lt_next, eq_next;

    // Ready ripples back from the consumer: a stage may load when it is empty
    // or when its current beat moves on during the same edge.
    assign s3_load   = s2_valid && (!s3_valid || out_ready);
    assign s2_load   = s1_valid && (!s2_valid || s3_load);
    assign in_ready  = !s1_valid || s2_load;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s3_valid;

    // NOTE: every variable assigned in always_comb gets a value on every path,
    // so no latch can be inferred.
    always_comb begin
        d_next  = a + b;
        e_next  = a + c;
        f_next  = a - b;
        eq_next = (d_next == e_next);
        lt_next = signed_mode ? ($signed(d_next) < $signed(e_next))
                              : (d_next < e_next);
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= s1_load || (s1_valid && !s2_load);
            s2_valid <= s2_load || (s2_valid && !s3_load);
            s3_valid <= s3_load || (s3_valid && !out_ready);
        end
    end

    // NOTE: data registers are cleared by reset as well, so x and z read zero
    // while held in reset; bubbles leave data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_d  <= '0;
            s1_e  <= '0;
            s1_f  <= '0;
            s1_lt <= 1'b0;
            s1_eq <= 1'b0;
        end else if (s1_load) begin
            s1_d  <= d_next;
            s1_e  <= e_next;
            s1_f  <= f_next;
            s1_lt <= lt_next;
            s1_eq <= eq_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_g  <= '0;
            s2_h  <= '0;
            s2_lt <= 1'b0;
            s2_eq <= 1'b0;
        end else if (s2_load) begin
            s2_g  <= s1_lt ? s1_d : s1_e;
            s2_h  <= s1_eq ? (s1_lt ? s1_d : s1_e) : s1_f;
            s2_lt <= s1_lt;
            s2_eq <= s1_eq;
        end
    end

    // Logical zero-filled shifts at full width, then keep the low OUT_WIDTH bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            z <= '0;
        end else if (s3_load) begin
            x <= OUT_WIDTH'(s2_lt ? (s2_h << SHIFT) : s2_h);
            z <= OUT_WIDTH'(s2_eq ? (s2_g >> SHIFT) : s2_g);
        end
    end

`ifdef CMP_SEL_SHIFT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= 16'h0000;
        end else if (s3_valid && out_ready && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_sel_shift_pipe.sv
// Directed self-checking bench for cmp_sel_shift_pipe (default parameters).
// Define CMP_SEL_SHIFT_STATS_EN to also exercise the handshake counter.
module tb_cmp_sel_shift_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b, c;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x, z;
`ifdef CMP_SEL_SHIFT_STATS_EN
    logic [15:0] xfer_count;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    // Hand-computed vectors: a, b, c, signed_mode -> x, z
    logic [63:0] va [5]  = '{64'd1, 64'd5, 64'd10, 64'd0, 64'd0};
    logic [63:0] vb [5]  = '{64'd2, 64'd2, 64'd5,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] vc [5]  = '{64'd3, 64'd2, 64'd1, 64'd1, 64'd1};
    logic        vsm [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vx [5]  = '{32'hFFFF_FFFE, 32'd7, 32'd5, 32'd1, 32'd2};
    logic [31:0] vz [5]  = '{32'd3, 32'd3, 32'd11, 32'd1, 32'hFFFF_FFFF};

    cmp_sel_shift_pipe #(
        .WIDTH(64),
        .OUT_WIDTH(32),
        .SHIFT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .c(c),
        .signed_mode(signed_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x(x),
        .z(z)
`ifdef CMP_SEL_SHIFT_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int i);
        a           = va[i];
        b           = vb[i];
        c           = vc[i];
        signed_mode = vsm[i];
        in_valid    = 1'b1;
    endtask

    // Single beat through an idle pipe; the accept edge counts as cycle 1.
    task automatic run_one(input int i);
        int lat;
        @(negedge clk);
        set_beat(i);
        #1 check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
        check($sformatf("v%0d_x", i), 64'(x), 64'(vx[i]));
        check($sformatf("v%0d_z", i), 64'(z), 64'(vz[i]));
        @(posedge clk);
        #1 check($sformatf("v%0d_drained", i), 64'(out_valid), 64'd0);
    endtask

    initial begin
        int  next_in;
        int  out_idx;
        bit  accepted;
        bit  stale;

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        c           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_x", 64'(x), 64'd0);
        check("rst_z", 64'(z), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 5; i++) run_one(i);

        // Backpressure: fill the pipe with out_ready low.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(i);
            #1 check($sformatf("bp_accept%0d_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        set_beat(3);
        #1 check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_full_out_valid", 64'(out_valid), 64'd1);
        check("bp_full_x", 64'(x), 64'(vx[0]));
        repeat (2) @(negedge clk);
        #1 check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_x", 64'(x), 64'(vx[0]));
        check("bp_hold_z", 64'(z), 64'(vz[0]));
        out_ready = 1'b1;
        #1 check("bp_release_in_ready", 64'(in_ready), 64'd1);

        next_in = 3;
        out_idx = 0;
        for (int cyc = 0; cyc < 20 && out_idx < 5; cyc++) begin
            #1;
            if (out_valid) begin
                check($sformatf("bp_out%0d_x", out_idx), 64'(x), 64'(vx[out_idx]));
                check($sformatf("bp_out%0d_z", out_idx), 64'(z), 64'(vz[out_idx]));
                out_idx++;
            end
            accepted = in_valid && in_ready;
            @(negedge clk);
            if (accepted) next_in++;
            if (next_in < 5) set_beat(next_in);
            else in_valid = 1'b0;
        end
        check("bp_out_count", 64'(out_idx), 64'd5);
        check("bp_in_count", 64'(next_in), 64'd5);
        @(negedge clk);
        check("bp_no_extra", 64'(out_valid), 64'd0);

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mid_pre_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1 check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_x", 64'(x), 64'd0);
        check("mid_rst_z", 64'(z), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1 check("mid_post_in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("mid_no_stale", 64'(stale), 64'd0);

`ifdef CMP_SEL_SHIFT_STATS_EN
        begin
            int hs;
            bit mid_done;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("cnt_reset", 64'(xfer_count), 64'd0);
            set_beat(0);
            out_ready = 1'b1;
            hs        = 0;
            mid_done  = 1'b0;
            for (int cyc = 0; cyc < 70100 && hs < 70000; cyc++) begin
                @(negedge clk);
                if (hs == 1000 && !mid_done) begin
                    check("cnt_1000", 64'(xfer_count), 64'd1000);
                    mid_done = 1'b1;
                end
                if (out_valid) hs++;
            end
            in_valid = 1'b0;
            check("cnt_handshakes", 64'(hs), 64'd70000);
            repeat (5) @(negedge clk);
            check("cnt_saturated", 64'(xfer_count), 64'hFFFF);
            rst = 1'b1;
            #1 check("cnt_cleared", 64'(xfer_count), 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
